// File: rtl/pc_fetch_pkg.sv
// Shared fetch-path definitions: bus widths, stall encoding, excepttype bit indices and boot address.
package pc_fetch_pkg;

   localparam int PC_TO_IC_WD  = 65;
   localparam int STALL_BUS_WD = 6;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam int ADEL_IF = 0;
   localparam int REFILL  = 1;
   localparam int INVALID = 2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

   typedef struct packed {
      logic [31:0] excepttype;
      logic        ce;
      logic [31:0] pc;
   } pc_to_ic_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-branch buffer: holds a branch target that arrived while the PC stage was stalled.
module pc_redirect_buf
   import pc_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        capture_i,
   input  logic [31:0] capture_addr_i,
   input  logic        consume_i,
   input  logic        clear_i,
   output logic        pend_v_o,
   output logic [31:0] pend_addr_o
);

   logic        pend_v_q;
   logic [31:0] pend_addr_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
      end else if (capture_i) begin
         pend_v_q    <= 1'b1;
         pend_addr_q <= capture_addr_i;
      end else if (consume_i || clear_i) begin
         pend_v_q    <= 1'b0;
      end
   end

   assign pend_v_o    = pend_v_q;
   assign pend_addr_o = pend_addr_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch initiator: owns the PC, drives the IC-stage bus and the instruction-SRAM request.
// Optional misaligned-fetch (AdEL) detection is enabled by defining PC_ADDR_CHECK_EN.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_BUS_WD-1:0] stall,
   input  logic                    flush,
   input  logic [31:0]             new_pc,
   input  logic                    br_e,
   input  logic [31:0]             br_addr,
   output logic [PC_TO_IC_WD-1:0]  pc_to_ic_bus,
   output logic                    inst_sram_en,
   output logic                    inst_sram_addr_unused_guard,
   output logic [31:0]             inst_sram_addr
);

   logic [31:0] pc_q, pc_d;
   logic        ce_q, ce_d;
   logic        pend_v;
   logic [31:0] pend_addr;
   logic        buf_capture, buf_consume, buf_clear;
   logic        pc_stop;
   logic        sram_en_raw;
   logic        adel;
   pc_to_ic_t   bus_s;

   assign pc_stop = (stall[0] == Stop);

   // Upper stall bits belong to later stages.
   logic unused_stall;
   assign unused_stall = ^stall[STALL_BUS_WD-1:1];
   assign inst_sram_addr_unused_guard = 1'b0;

   pc_redirect_buf u_redirect_buf (
      .clk            (clk),
      .rst            (rst),
      .capture_i      (buf_capture),
      .capture_addr_i (br_addr),
      .consume_i      (buf_consume),
      .clear_i        (buf_clear),
      .pend_v_o       (pend_v),
      .pend_addr_o    (pend_addr)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      pc_d        = pc_q;
      ce_d        = ce_q;
      buf_capture = 1'b0;
      buf_consume = 1'b0;
      buf_clear   = 1'b0;
      if (flush) begin
         pc_d      = new_pc;
         ce_d      = 1'b1;
         buf_clear = 1'b1;
      end else if (br_e && !pc_stop) begin
         pc_d      = br_addr;
         ce_d      = 1'b1;
         buf_clear = 1'b1;
      end else if (br_e) begin
         buf_capture = 1'b1;
      end else if (pc_stop) begin
         pc_d = pc_q;
      end else if (pend_v) begin
         pc_d        = pend_addr;
         ce_d        = 1'b1;
         buf_consume = 1'b1;
      end else begin
         pc_d = pc_q + 32'd4;
         ce_d = 1'b1;
      end
   end

   assign sram_en_raw    = flush | (ce_d & !pc_stop);
   assign inst_sram_addr = pc_d;

`ifdef PC_ADDR_CHECK_EN
   assign adel         = |pc_q[1:0];
   assign inst_sram_en = sram_en_raw & ~(|pc_d[1:0]);
`else
   assign adel         = 1'b0;
   assign inst_sram_en = sram_en_raw;
`endif

   always_comb begin
      bus_s                     = '0;
      bus_s.excepttype[ADEL_IF] = adel;
      bus_s.ce                  = ce_q;
      bus_s.pc                  = pc_q;
   end

   assign pc_to_ic_bus = bus_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC - 32'd4;
         ce_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         ce_q <= ce_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch: boot, +4 advance, branches, stalled branch, flush, wrap, reset.
module tb_pc_fetch;
   import pc_fetch_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [STALL_BUS_WD-1:0] stall;
   logic                    flush;
   logic [31:0]             new_pc;
   logic                    br_e;
   logic [31:0]             br_addr;
   logic [PC_TO_IC_WD-1:0]  pc_to_ic_bus;
   logic                    inst_sram_en;
   logic                    guard;
   logic [31:0]             inst_sram_addr;

   int checks = 0;
   int errors = 0;

`ifdef PC_ADDR_CHECK_EN
   localparam logic [31:0] EXP_MIS_EXC = 32'h1;
   localparam logic        EXP_MIS_EN  = 1'b0;
`else
   localparam logic [31:0] EXP_MIS_EXC = 32'h0;
   localparam logic        EXP_MIS_EN  = 1'b1;
`endif

   pc_fetch dut (
      .clk                         (clk),
      .rst                         (rst),
      .stall                       (stall),
      .flush                       (flush),
      .new_pc                      (new_pc),
      .br_e                        (br_e),
      .br_addr                     (br_addr),
      .pc_to_ic_bus                (pc_to_ic_bus),
      .inst_sram_en                (inst_sram_en),
      .inst_sram_addr_unused_guard (guard),
      .inst_sram_addr              (inst_sram_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_bus(input string tag, input logic ce, input logic [31:0] pc,
                            input logic [31:0] exc);
      check({tag, ".pc"}, 65'(pc_to_ic_bus[31:0]), 65'(pc));
      check({tag, ".ce"}, 65'(pc_to_ic_bus[32]), 65'(ce));
      check({tag, ".exc"}, 65'(pc_to_ic_bus[64:33]), 65'(exc));
   endtask

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; br_e = 1'b0; br_addr = '0;
      tick(); tick();
      check_bus("reset", 1'b0, 32'hBFBF_FFFC, 32'h0);
      check("reset.pend_v", 65'(dut.pend_v), 65'(1'b0));

      // Boot sequence
      rst = 1'b0; settle();
      check_bus("boot0", 1'b0, 32'hBFBF_FFFC, 32'h0);
      check("boot0.addr", 65'(inst_sram_addr), 65'(32'hBFC0_0000));
      check("boot0.en", 65'(inst_sram_en), 65'(1'b1));
      tick();
      check_bus("boot1", 1'b1, 32'hBFC0_0000, 32'h0);
      check("boot1.addr", 65'(inst_sram_addr), 65'(32'hBFC0_0004));
      tick();
      check_bus("seq4", 1'b1, 32'hBFC0_0004, 32'h0);
      tick();
      check_bus("seq8", 1'b1, 32'hBFC0_0008, 32'h0);

      // Unstalled branch
      br_e = 1'b1; br_addr = 32'hBFC0_0100; settle();
      check("br.addr", 65'(inst_sram_addr), 65'(32'hBFC0_0100));
      check("br.en", 65'(inst_sram_en), 65'(1'b1));
      tick(); br_e = 1'b0; settle();
      check_bus("br.t1", 1'b1, 32'hBFC0_0100, 32'h0);
      tick();
      check_bus("br.t2", 1'b1, 32'hBFC0_0104, 32'h0);

      // Branch arriving during a three-cycle stall
      stall = 6'b000001; settle();
      check("stall1.en", 65'(inst_sram_en), 65'(1'b0));
      check("stall1.addr", 65'(inst_sram_addr), 65'(32'hBFC0_0104));
      tick();
      check_bus("stall1", 1'b1, 32'hBFC0_0104, 32'h0);
      br_e = 1'b1; br_addr = 32'hBFC0_0200; settle();
      tick(); br_e = 1'b0; settle();
      check_bus("stall2", 1'b1, 32'hBFC0_0104, 32'h0);
      check("stall2.pend_v", 65'(dut.pend_v), 65'(1'b1));
      tick();
      check_bus("stall3", 1'b1, 32'hBFC0_0104, 32'h0);
      stall = '0; settle();
      check("release.addr", 65'(inst_sram_addr), 65'(32'hBFC0_0200));
      check("release.en", 65'(inst_sram_en), 65'(1'b1));
      tick();
      check_bus("release.t1", 1'b1, 32'hBFC0_0200, 32'h0);
      check("release.pend_v", 65'(dut.pend_v), 65'(1'b0));
      tick();
      check_bus("release.t2", 1'b1, 32'hBFC0_0204, 32'h0);

      // Flush beats a simultaneous stalled branch
      stall = 6'b000001; br_e = 1'b1; br_addr = 32'hBFC0_0300;
      flush = 1'b1; new_pc = 32'hBFC0_0380; settle();
      check("flush.en", 65'(inst_sram_en), 65'(1'b1));
      check("flush.addr", 65'(inst_sram_addr), 65'(32'hBFC0_0380));
      tick();
      stall = '0; br_e = 1'b0; flush = 1'b0; settle();
      check_bus("flush.t1", 1'b1, 32'hBFC0_0380, 32'h0);
      check("flush.pend_v", 65'(dut.pend_v), 65'(1'b0));
      tick();
      check_bus("flush.t2", 1'b1, 32'hBFC0_0384, 32'h0);

      // Misaligned branch target
      br_e = 1'b1; br_addr = 32'hBFC0_0102; settle();
      check("mis.addr", 65'(inst_sram_addr), 65'(32'hBFC0_0102));
      check("mis.en", 65'(inst_sram_en), 65'(EXP_MIS_EN));
      tick(); br_e = 1'b0; settle();
      check_bus("mis.t1", 1'b1, 32'hBFC0_0102, EXP_MIS_EXC);

      // Wraparound at the top of the address space
      flush = 1'b1; new_pc = 32'hFFFF_FFF8; settle();
      tick(); flush = 1'b0; settle();
      check_bus("wrap.fff8", 1'b1, 32'hFFFF_FFF8, 32'h0);
      tick();
      check_bus("wrap.fffc", 1'b1, 32'hFFFF_FFFC, 32'h0);
      check("wrap.addr", 65'(inst_sram_addr), 65'(32'h0000_0000));
      tick();
      check_bus("wrap.zero", 1'b1, 32'h0000_0000, 32'h0);

      // Reset while stalled with a pending branch
      stall = 6'b000001; br_e = 1'b1; br_addr = 32'hBFC0_0500; settle();
      tick(); br_e = 1'b0; settle();
      check("rstpend.pend_v", 65'(dut.pend_v), 65'(1'b1));
      rst = 1'b1; settle();
      tick();
      check_bus("rstpend.bus", 1'b0, 32'hBFBF_FFFC, 32'h0);
      check("rstpend.pend_v0", 65'(dut.pend_v), 65'(1'b0));
      rst = 1'b0; stall = '0; settle();
      tick();
      check_bus("rstpend.boot", 1'b1, 32'hBFC0_0000, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
